mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_pkg.sv | 20 ++
 rtl/mult_div_unit_md_iter_step.sv | 34 +++
 rtl/mult_div_unit.sv | 123 ++++++++++++
 tb/tb_mult_div_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_div_unit_pkg : shared constants and state encoding for mult_div_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
package mult_div_unit_pkg;

  localparam int         c_width      = 32;
  localparam logic [4:0] c_alu_opcode = 5'd0;
  localparam logic [4:0] c_aluop_mul  = 5'd6;
  localparam logic [4:0] c_aluop_div  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_md_iter_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_iter_step : one shift-add (MUL) or restoring trial-subtract (DIV) step
// Revision: 1.0
// ---------------------------------------------------------------------------
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_opnd,
  output logic [2*WIDTH-1:0]   o_acc_nxt
);

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_shl;

  // Upper half holds the partial product / partial remainder.
  assign w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
  assign w_shl  = {i_acc[2*WIDTH-2:0], 1'b0};
  assign w_diff = {1'b0, w_shl[2*WIDTH-1:WIDTH]} - {1'b0, i_opnd};

  always_comb begin
    o_acc_nxt = i_acc;
    if (i_is_div) begin
      o_acc_nxt = w_diff[WIDTH] ? w_shl : {w_diff[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};
    end else begin
      o_acc_nxt = i_acc[0] ? {w_sum, i_acc[WIDTH-1:1]} : {1'b0, i_acc[2*WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_div_unit : multi-cycle signed multiply/divide with tagged writeback
// Revision: 1.0
// ---------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = c_width,
  parameter int TAG_W = 5,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAG_W-1:0] tag_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  md_state_t            r_state, w_state_nxt;
  logic [4:0]           r_op;
  logic                 r_sign;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [TAG_W-1:0]     r_tag;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_start, w_accept, w_last, w_is_div;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot, w_res;
  logic                 w_exc;

  assign w_start  = ctrl_MULT | ctrl_DIV;
  assign w_accept = w_start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == c_last);
  assign w_is_div = (r_op == c_aluop_div);
  assign w_mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign busy     = (r_state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = w_start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div  (w_is_div),
    .i_acc     (r_acc),
    .i_opnd    (r_opnd),
    .o_acc_nxt (w_acc_nxt)
  );

  // Sign fixup; a quotient magnitude of 2^WIDTH-1 only stays legal when negated.
  always_comb begin
    w_prod = r_sign ? -r_acc : r_acc;
    w_quot = r_sign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_res  = w_prod[WIDTH-1:0];
    w_exc  = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    if (w_is_div) begin
      if (r_opnd == '0) begin
        w_res = '0;
        w_exc = 1'b1;
      end else begin
        w_res = w_quot;
        w_exc = ~r_sign & r_acc[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op           <= c_aluop_mul;
      r_sign         <= 1'b0;
      r_opnd         <= '0;
      r_acc          <= '0;
      r_tag          <= '0;
      r_cnt          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      tag_out        <= '0;
    end else begin
      data_resultRDY <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        data_result    <= w_res;
        data_exception <= w_exc;
        tag_out        <= r_tag;
      end
      if (w_accept) begin
        r_op   <= ctrl_MULT ? c_aluop_mul : c_aluop_div;
        r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_opnd <= w_mag_b;
        r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
        r_tag  <= tag_in;
        r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc  <= w_acc_nxt;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_div_unit : directed bench with an arithmetic reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV  = 1'b0;
  logic [31:0] op_a      = '0;
  logic [31:0] op_b      = '0;
  logic [4:0]  tag_in    = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [4:0]  tag_out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mult_div_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .tag_in         (tag_in),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .tag_out        (tag_out),
    .busy           (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: {exception, result}
  function automatic logic [32:0] mdl(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mul) begin
      p = sa * sb;
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'h80000000};
    q = sa / sb;
    return {1'b0, q[31:0]};
  endfunction

  // Timing model: op accepted at edge k is busy after edges k..k+31,
  // and its result appears (with a one-cycle ready) after edge k+33.
  bit          m_active = 1'b0, m_busy = 1'b0, m_rdy = 1'b0, m_exc = 1'b0, p_exc = 1'b0;
  logic [31:0] m_res = '0, p_res = '0;
  logic [4:0]  m_tag = '0, p_tag = '0;
  int          e = 0, m_k = 0;

  always @(posedge clock or negedge reset_n) begin : b_model
    bit run_before;
    if (!reset_n) begin
      m_active = 1'b0; m_busy = 1'b0; m_rdy = 1'b0;
      m_exc = 1'b0; m_res = '0; m_tag = '0; e = 0;
    end else begin
      e++;
      run_before = m_active && ((e - 1 - m_k) <= 31);
      m_rdy = 1'b0;
      if (m_active && (e - m_k) == 33) begin
        m_rdy = 1'b1; m_res = p_res; m_exc = p_exc; m_tag = p_tag;
        m_active = 1'b0;
      end
      if (!run_before && (ctrl_MULT || ctrl_DIV)) begin
        m_active = 1'b1;
        m_k = e;
        {p_exc, p_res} = mdl(ctrl_MULT, op_a, op_b);
        p_tag = tag_in;
      end
      m_busy = m_active && ((e - m_k) <= 31);
    end
  end

  always @(negedge clock) begin
    chk("busy", busy, m_busy);
    chk("resultRDY", data_resultRDY, m_rdy);
    chk("result", data_result, m_res);
    chk("exception", data_exception, m_exc);
    chk("tag_out", tag_out, m_tag);
  end

  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    ctrl_MULT = m; ctrl_DIV = d; op_a = a; op_b = b; tag_in = t;
  endtask

  // Called on the negedge the start was driven; latency counts negedges to ready.
  task automatic expect_done(input string nm, input int exp_lat, input logic [31:0] r,
                             input logic ex, input logic [4:0] t, input int inj_at,
                             input bit im, input bit id, input logic [31:0] ia,
                             input logic [31:0] ib, input logic [4:0] it);
    int lat = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
      if (i == inj_at) start(im, id, ia, ib, it);
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " result"}, data_result, r);
    chk({nm, " exception"}, data_exception, ex);
    chk({nm, " tag"}, tag_out, t);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clock);
    chk("reset busy", busy, 0);
    chk("reset rdy", data_resultRDY, 0);
    chk("reset result", data_result, 0);
    reset_n = 1'b1;
    @(negedge clock);

    start(1, 0, 32'd7, 32'hFFFFFFFD, 5'd5);
    expect_done("mul 7*-3", 34, 32'hFFFFFFEB, 0, 5'd5, 0, 0, 0, 0, 0, 0);

    start(0, 1, 32'hFFFFFF9C, 32'd7, 5'd1);
    expect_done("div -100/7", 34, 32'hFFFFFFF2, 0, 5'd1, 33, 0, 1, 32'd100, 32'd7, 5'd2);
    expect_done("div 100/7 chained", 33, 32'd14, 0, 5'd2, 0, 0, 0, 0, 0, 0);

    start(0, 1, 32'd123, 32'd0, 5'd6);
    expect_done("div by zero", 34, 32'd0, 1, 5'd6, 0, 0, 0, 0, 0, 0);
    start(0, 1, 32'h80000000, 32'hFFFFFFFF, 5'd7);
    expect_done("div min/-1", 34, 32'h80000000, 1, 5'd7, 0, 0, 0, 0, 0, 0);

    start(1, 0, 32'h00010000, 32'h00010000, 5'd8);
    expect_done("mul overflow", 34, 32'd0, 1, 5'd8, 0, 0, 0, 0, 0, 0);
    start(1, 1, 32'h80000000, 32'd1, 5'd10);
    expect_done("mul min*1 both ctrl", 34, 32'h80000000, 0, 5'd10, 0, 0, 0, 0, 0, 0);

    start(1, 0, 32'd3, 32'd4, 5'd3);
    expect_done("mul 3*4 div ignored", 34, 32'd12, 0, 5'd3, 11, 0, 1, 32'd9, 32'd3, 5'd11);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) seen = 1'b1;
    end
    chk("single rdy pulse", seen, 0);

    start(1, 0, 32'd3, 32'd4, 5'd9);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset rdy", data_resultRDY, 0);
    chk("async reset result", data_result, 0);
    chk("async reset exception", data_exception, 0);
    chk("async reset tag", tag_out, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) seen = 1'b1;
    end
    chk("no rdy after reset", seen, 0);

    start(1, 0, 32'd2, 32'd2, 5'd4);
    expect_done("mul 2*2 after reset", 34, 32'd4, 0, 5'd4, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
